// File: rtl/wb_pkg.sv
// Shared Wishbone B3 types, arbiter FSM states and watchdog sizing helper.
package wb_pkg;

  localparam int unsigned WbAddrW = 32;
  localparam int unsigned WbDataW = 32;
  localparam int unsigned WbSelW  = WbDataW / 8;

  typedef logic [WbAddrW-1:0] wb_addr_range;
  typedef logic [WbDataW-1:0] wb_data_t;
  typedef logic [WbSelW-1:0]  wb_sel_t;

  typedef enum logic [0:0] {
    StIdle,
    StBusy
  } arb_state_e;

  // Counter width able to hold 0..timeout; never narrower than one bit.
  function automatic int unsigned wdog_width(int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wishbone_b3.sv
// Wishbone B3 classic bus bundle with master and slave views.
interface wishbone_b3;
  import wb_pkg::*;

  wb_addr_range adr;
  wb_data_t     dat_m2s;
  wb_data_t     dat_s2m;
  wb_sel_t      sel;
  logic         cyc;
  logic         stb;
  logic         we;
  logic [2:0]   cti;
  logic [1:0]   bte;
  logic         ack;
  logic         err;
  logic         rty;

  modport master (
    output adr, dat_m2s, sel, cyc, stb, we, cti, bte,
    input  dat_s2m, ack, err, rty
  );

  modport slave (
    input  adr, dat_m2s, sel, cyc, stb, we, cti, bte,
    output dat_s2m, ack, err, rty
  );

endinterface

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after the one-hot last owner.
module wb_rr_pick #(
  parameter int unsigned MASTERS = 3
) (
  input  logic [MASTERS-1:0] req,
  input  logic [MASTERS-1:0] last,
  output logic [MASTERS-1:0] pick,
  output logic               valid
);

  localparam int unsigned IdxW = $clog2(MASTERS);

  logic [IdxW-1:0] last_idx;
  logic [IdxW-1:0] idx;

  // Encode the one-hot last owner into an index.
  always_comb begin
    last_idx = '0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (last[i]) last_idx = IdxW'(i);
    end
  end

  // Walk the wrap-around order starting one past last; the first hit wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int unsigned k = 1; k <= MASTERS; k++) begin
      idx = IdxW'((32'(last_idx) + k) % MASTERS);
      if ((pick == '0) && req[idx]) pick[idx] = 1'b1;
    end
  end

  assign valid = |req;

endmodule

// File: rtl/wb_arbiter_rr_b3.sv
// Round-robin Wishbone B3 arbiter: N masters share one slave, with a stall watchdog.
module wb_arbiter_rr_b3
  import wb_pkg::*;
#(
  parameter int unsigned MASTERS = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  wishbone_b3.slave          master [MASTERS],
  wishbone_b3.master         slave,
  output logic [MASTERS-1:0] grant,
  output logic               timeout
);

  localparam int unsigned        WdW      = wdog_width(TIMEOUT);
  localparam logic [WdW-1:0]     WdLimit  = WdW'(TIMEOUT);
  localparam logic [MASTERS-1:0] LastInit = {1'b1, {(MASTERS-1){1'b0}}};

  arb_state_e         state_q, state_d;
  logic [MASTERS-1:0] grant_q, grant_d;
  logic [MASTERS-1:0] last_q, last_d;
  logic [WdW-1:0]     wd_q, wd_d;

  logic [MASTERS-1:0] m_cyc, m_stb, m_we;
  wb_addr_range       m_adr [MASTERS];
  wb_data_t           m_dat [MASTERS];
  wb_sel_t            m_sel [MASTERS];
  logic [2:0]         m_cti [MASTERS];
  logic [1:0]         m_bte [MASTERS];

  logic [MASTERS-1:0] pick;
  logic               pick_valid;

  wb_addr_range o_adr;
  wb_data_t     o_dat;
  wb_sel_t      o_sel;
  logic [2:0]   o_cti;
  logic [1:0]   o_bte;
  logic         o_we;
  logic         own_cyc, own_stb, slv_resp, wd_fire;

  // Per-master flattening and response routing; grant_q is zero when idle.
  for (genvar i = 0; i < MASTERS; i++) begin : g_master
    assign m_cyc[i] = master[i].cyc;
    assign m_stb[i] = master[i].stb;
    assign m_we[i]  = master[i].we;
    assign m_adr[i] = master[i].adr;
    assign m_dat[i] = master[i].dat_m2s;
    assign m_sel[i] = master[i].sel;
    assign m_cti[i] = master[i].cti;
    assign m_bte[i] = master[i].bte;

    assign master[i].dat_s2m = grant_q[i] ? slave.dat_s2m : '0;
    assign master[i].ack     = grant_q[i] & slave.ack;
    assign master[i].err     = grant_q[i] & (slave.err | wd_fire);
    assign master[i].rty     = grant_q[i] & slave.rty;
  end

  wb_rr_pick #(
    .MASTERS(MASTERS)
  ) u_pick (
    .req  (m_cyc),
    .last (last_q),
    .pick (pick),
    .valid(pick_valid)
  );

  // Forward the owner's request fields to the slave; all zero with no owner.
  always_comb begin
    o_adr = '0;
    o_dat = '0;
    o_sel = '0;
    o_cti = '0;
    o_bte = '0;
    o_we  = 1'b0;
    for (int unsigned i = 0; i < MASTERS; i++) begin
      if (grant_q[i]) begin
        o_adr = m_adr[i];
        o_dat = m_dat[i];
        o_sel = m_sel[i];
        o_cti = m_cti[i];
        o_bte = m_bte[i];
        o_we  = m_we[i];
      end
    end
  end

  assign own_cyc  = |(grant_q & m_cyc);
  assign own_stb  = |(grant_q & m_stb);
  assign slv_resp = slave.ack | slave.err | slave.rty;

  // A real slave response in the limit cycle beats the watchdog.
  assign wd_fire = (TIMEOUT != 0) && (state_q == StBusy) && own_stb && !slv_resp &&
                   (wd_q == WdLimit);

  assign slave.adr     = o_adr;
  assign slave.dat_m2s = o_dat;
  assign slave.sel     = o_sel;
  assign slave.cti     = o_cti;
  assign slave.bte     = o_bte;
  assign slave.we      = o_we;
  assign slave.cyc     = own_cyc;
  assign slave.stb     = own_stb & ~wd_fire;

  assign grant   = grant_q;
  assign timeout = wd_fire;

  // Watchdog counts stalled strobe cycles of the owner and clears on anything else.
  always_comb begin
    wd_d = '0;
    if ((TIMEOUT != 0) && (state_q == StBusy) && own_stb && !slv_resp && !wd_fire) begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Arbitration FSM: grant on any request when idle, hold until the owner drops cyc.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StBusy;
          grant_d = pick;
          last_d  = pick;
        end
      end
      StBusy: begin
        if (!own_cyc) begin
          state_d = StIdle;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset drops the grant and hence the slave bus immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= LastInit;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: doc/wb_arbiter_rr_b3.md
WB_ARBITER_RR_B3 -- requirements
Module: wb_arbiter_rr_b3

Interface
REQ-001 The block SHALL have parameter MASTERS, default 3: number of requesting Wishbone masters, legal range 2..8.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: watchdog limit in cycles, where 0 disables the watchdog.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port master, wishbone_b3.slave [MASTERS]: requesters.
REQ-006 The block SHALL have port slave, wishbone_b3.master: shared downstream bus.
REQ-007 The block SHALL have port grant, output, MASTERS bits: one-hot registered owner; all zero when idle.
REQ-008 The block SHALL have port timeout, output, 1 bit: single-cycle pulse when the watchdog fires.

Function
REQ-009 The block SHALL implement an FSM with states IDLE and BUSY.
REQ-010 IDLE: slave.cyc, slave.stb and slave.we SHALL be 0, and every other slave-side signal SHALL be 0.
REQ-011 IDLE: every master's dat_s2m/ack/err/rty SHALL be 0.
REQ-012 IDLE: if any master[i].cyc=1, the block SHALL select the first requester strictly after last_grant in ascending wrap-around order, load grant, update last_grant, and enter BUSY at the next edge.
REQ-013 Arbitration latency SHALL be exactly one cycle: the request is seen in cycle N, and the owner drives the slave from cycle N+1.
REQ-014 BUSY: slave adr/cyc/dat_m2s/sel/we/stb/cti/bte SHALL equal the owner's, combinationally.
REQ-015 BUSY: the owner SHALL receive slave dat_s2m/ack/err/rty combinationally, and non-owners SHALL receive 0.
REQ-016 BUSY: the owner's cyc=0 SHALL return the FSM to IDLE at the next edge, clearing grant, with no pre-emption while the owner holds cyc.
REQ-017 New requests in the same cycle the owner releases SHALL be arbitrated in the following IDLE cycle, giving a one-cycle bus gap between owners.
REQ-018 Requests from non-owners during BUSY SHALL be ignored, with no queuing beyond the master holding cyc.
REQ-019 After power-up, last_grant SHALL be MASTERS-1 so that master 0 wins first.
REQ-020 Watchdog: a counter of width $clog2(TIMEOUT+1) SHALL increment each BUSY cycle with owner stb=1 and slave ack=err=rty=0, and clear otherwise.
REQ-021 When the watchdog counter equals TIMEOUT (TIMEOUT>0), for that one cycle the owner SHALL see err=1 and ack=rty=0, slave.stb SHALL be forced 0, timeout SHALL pulse 1, and the counter SHALL clear.
REQ-022 If the slave responds in the same cycle the counter reaches TIMEOUT, the slave response SHALL win: no err and no timeout pulse.
REQ-023 A master releasing cyc in the timeout cycle SHALL follow REQ-016.
REQ-024 If TIMEOUT=0, the watchdog counter SHALL stay 0 and timeout SHALL never assert.

Reset
REQ-025 While rst_n=0 the block SHALL hold state IDLE, grant=0, timeout=0, counter=0 and last_grant=MASTERS-1, and the slave-side outputs SHALL be 0.
REQ-026 Reset asserted mid-transfer SHALL drop slave.cyc to 0 immediately (asynchronously), with no completion of the in-flight access.
REQ-027 After rst_n deasserts, the first arbitration SHALL occur on the first edge where any cyc=1.

Structure
REQ-028 Typedef wb_addr_range, the timeout-width function and any FSM state enum SHALL live in shared package wb_pkg, and this block SHALL import it.
REQ-029 Round-robin selection SHALL be sub-module wb_rr_pick (purely combinational: inputs req[MASTERS] and last[MASTERS]; outputs one-hot pick[MASTERS] and valid).
REQ-030 Per-master muxing SHALL use generate loops over MASTERS, with no hard-coded master indices.

Verification
REQ-031 The bench SHALL cover: reset, then master1 cyc=stb=1 at cycle 0 -> grant=3'b010 at cycle 1, slave.adr=master1.adr from cycle 1, and master1 ack mirrors slave ack.
REQ-032 The bench SHALL cover: all three masters holding cyc continuously, each releasing after one ack -> grant sequence 001,010,100,001 with exactly one idle cycle between grants.
REQ-033 The bench SHALL cover: TIMEOUT=4 and a slave that never acks -> owner err=1 and timeout=1 in the 5th stalled cycle with slave.stb=0 that cycle; after the owner drops cyc, the next master is granted.
REQ-034 The bench SHALL cover: TIMEOUT=4 with slave ack in the cycle the counter reaches 4 -> owner ack=1, err=0, timeout=0.
REQ-035 The bench SHALL cover: rst_n pulled low mid-burst while master2 owns the bus -> slave.cyc=0 and grant=0 within the reset cycle; after release, master0 and master2 requesting together -> master0 granted.
REQ-036 The bench SHALL cover: TIMEOUT=0 with a stalled slave for 1000 cycles -> no err and no timeout pulse, and grant holds the owner.
